// File: rtl/soc_bus_fabric_pkg.sv
// rtl/soc_bus_fabric_pkg.sv - shared state encodings and slave map for the data-bus fabric
package soc_bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_e;

  localparam int DEFAULT_SELW = 4;

  localparam int SLV_RAM  = 0;
  localparam int SLV_UART = 1;
  localparam int SLV_GPIO = 2;
  localparam int SLV_TMR  = 3;

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - maps the top address field onto a slave index
module bus_addr_decoder #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter int SELW = 4
) (
  input  logic [AW-1:0]   addr,
  output logic [SELW-1:0] sel,
  output logic            hit
);

  // Only the slave-select field decodes; the offset belongs to the slave.
  logic unused_offset;
  assign unused_offset = ^addr[AW-SELW-1:0];

  assign sel = addr[AW-1 -: SELW];
  assign hit = (32'(sel) < NSLV);

endmodule

// File: rtl/soc_bus_fabric.sv
// rtl/soc_bus_fabric.sv - single-master data-bus fabric with ACK handshake and bus errors
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SELW    = DEFAULT_SELW,
  parameter int TIMEOUT = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iM_REQ,
  input  logic              iM_WR,
  input  logic [DW/8-1:0]   iM_BE,
  input  logic [AW-1:0]     iM_ADDR,
  input  logic [DW-1:0]     iM_WDATA,
  output logic [DW-1:0]     oM_RDATA,
  output logic              oM_ACK,
  output logic              oM_ERR,
  output logic              oBUSY,
  output logic [NSLV-1:0]   oS_CE,
  output logic [NSLV-1:0]   oS_RD,
  output logic [NSLV-1:0]   oS_WR,
  output logic [AW-1:0]     oS_ADDR,
  output logic [DW-1:0]     oS_WDATA,
  output logic [DW/8-1:0]   oS_BE,
  input  logic [NSLV*DW-1:0] iS_RDATA,
  input  logic [NSLV-1:0]   iS_ACK
);

  localparam int CNTW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [SELW-1:0]   dec_sel;
  logic              dec_hit;

  bus_addr_decoder #(
    .NSLV (NSLV),
    .AW   (AW),
    .SELW (SELW)
  ) u_dec (
    .addr (iM_ADDR),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Selected slave's strobe, ACK and read data, from the latched index only.
  logic [NSLV-1:0] sel_hot;
  logic            ack_sel;
  logic [DW-1:0]   rdata_sel;

  always_comb begin
    sel_hot   = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (32'(sel_q) == i) begin
        sel_hot[i] = 1'b1;
        ack_sel    = iS_ACK[i];
        rdata_sel  = iS_RDATA[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (iM_REQ) begin
          addr_d  = iM_ADDR;
          wr_d    = iM_WR;
          be_d    = iM_BE;
          wdata_d = iM_WDATA;
          sel_d   = dec_sel;
          cnt_d   = '0;
          rdata_d = '0;
          state_d = dec_hit ? ST_ACCESS : ST_ERR;
        end
      end
      ST_ACCESS: begin
        // ACK is checked first so it beats a coincident timeout.
        if (ack_sel) begin
          rdata_d = wr_q ? '0 : rdata_sel;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = ST_ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign oS_CE    = (state_q == ST_ACCESS) ? sel_hot : '0;
  assign oS_RD    = wr_q ? '0 : oS_CE;
  assign oS_WR    = wr_q ? oS_CE : '0;
  assign oS_ADDR  = addr_q;
  assign oS_WDATA = wdata_q;
  assign oS_BE    = be_q;
  assign oM_ACK   = (state_q == ST_RESP);
  assign oM_ERR   = (state_q == ST_ERR);
  assign oM_RDATA = oM_ACK ? rdata_q : '0;
  assign oBUSY    = (state_q != ST_IDLE);

endmodule
